// File: rtl/high_speed_bus_ecc_checker.sv
// rtl/high_speed_bus_ecc_checker.sv - ECC syndrome checker for {data[31:0], ecc[6:0]} words
// Two-stage valid/ready pipeline (S1 = check register, S2 = output register) plus error statistics.
module high_speed_bus_ecc_checker #(
  parameter int CNT_W       = 16,
  parameter bit DROP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [38:0]      in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_err,
  output logic [6:0]       out_syndrome,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sticky,
  input  logic             clr_stats
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0] in_data;
  logic [6:0]  calc_ecc;
  logic [6:0]  syndrome;
  logic        err;
  logic        accept;
  logic        s2_load;

  logic        s1_valid;
  logic [31:0] s1_data;
  logic [6:0]  s1_syndrome;

  assign in_data = in_word[38:7];

  always_comb begin
    calc_ecc    = '0;
    calc_ecc[0] = ^in_data[31:0];
    calc_ecc[1] = ^in_data[15:0];
    calc_ecc[2] = ^in_data[7:0];
    calc_ecc[3] = ^in_data[3:0];
    calc_ecc[4] = ^in_data[1:0];
    calc_ecc[5] = in_data[0];
    calc_ecc[6] = ^{in_data[31:16], in_data[7:0]};
  end

  assign syndrome = in_word[6:0] ^ calc_ecc;
  assign err      = |syndrome;

  // Ready looks only at pipeline occupancy and the downstream ready, never at in_valid.
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign s2_load  = s1_valid && (!out_valid || out_ready);

  // With DROP_ON_ERR an errored word is consumed here and never occupies S1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s1_syndrome <= '0;
    end else if (accept) begin
      s1_valid    <= !(DROP_ON_ERR && err);
      s1_data     <= in_data;
      s1_syndrome <= syndrome;
    end else if (s2_load) begin
      s1_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_err      <= 1'b0;
      out_syndrome <= '0;
    end else if (s2_load) begin
      out_valid    <= 1'b1;
      out_data     <= s1_data;
      out_err      <= |s1_syndrome;
      out_syndrome <= s1_syndrome;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  // A clear coinciding with an errored acceptance leaves that word counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else if (clr_stats) begin
      err_count  <= (accept && err) ? CNT_ONE : '0;
      err_sticky <= accept && err;
    end else if (accept && err) begin
      if (err_count != CNT_MAX) begin
        err_count <= err_count + CNT_ONE;
      end
      err_sticky <= 1'b1;
    end
  end

endmodule
